rst_sequencer: RTL and testbench
================================

// Module: rst_sequencer
// PURPOSE
//  Parametrised successor to the board-level reset synchroniser. Filters and synchronises the
//  clock-wizard lock, then releases NCH active-low reset domains in a fixed staggered order.
//  Re-asserts on lock loss or software request, and counts lock-loss events. Sits in the FPGA
//  top between clk_wiz and the core/peripheral domains (poco_r = ch0, LED/IO = higher ch).
// PARAMETERS
//  NCH          4   number of reset channels (1..16); ch0 released first
//  SYNC_STAGES  2   flops in locked_in synchroniser (>=2)
//  LOCK_FILT    16  consecutive synced-lock cycles required before release (>=1)
//  HOLD_CYC     8   cycles between successive channel releases/asserts (>=1)
// PORTS
//  clk           in   1    single clock (clk_wiz output)
//  rst           in   1    synchronous, active-high reset
//  locked_in     in   1    PLL lock, asynchronous to clk
//  sw_rst_req    in   1    one-cycle software reset request, synchronous
//  rst_n_out     out  NCH  per-channel active-low resets, registered
//  all_released  out  1    high while every channel is released (state RUN)
//  state_o       out  3    current FSM state encoding (debug)
//  lock_loss_cnt out  8    saturating count of lock-loss events since rst
// BEHAVIOUR
//  - rst=1: state ASSERT, rst_n_out=0, all_released=0, counters=0, lock_loss_cnt=0, sync chain=0.
//  - locked_in -> SYNC_STAGES-flop chain -> lk (lk lags locked_in by SYNC_STAGES cycles).
//  - ASSERT: all rst_n_out=0; next cycle -> WAIT_LOCK.
//  - WAIT_LOCK: filt_cnt++ while lk=1, cleared when lk=0; enter RELEASE on the edge where
//    lk=1 and filt_cnt==LOCK_FILT-1 (LOCK_FILT cycles after lk first high). sw_rst_req ignored.
//  - RELEASE: hold_cnt counts 0..HOLD_CYC-1; at wrap, rst_n_out[idx]<=1, idx++. ch k rises
//    (k+1)*HOLD_CYC cycles after RELEASE entry. Release of ch NCH-1 -> RUN same edge;
//    all_released rises together with rst_n_out[NCH-1].
//  - RUN: outputs stable, all_released=1.
//  - Lock loss (lk=0 in RELEASE/RUN/DRAIN): next edge -> ASSERT, all rst_n_out=0 at once,
//    lock_loss_cnt++ (saturates at 255). Takes priority over sw_rst_req in the same cycle.
//  - sw_rst_req in RELEASE/RUN: -> ASSERT (or DRAIN, see CONFIGURATION); not counted.
//  - rst mid-sequence overrides all; counters, idx, lock_loss_cnt cleared.
//  - Counter widths $clog2 of limit, min 1; idx width $clog2(NCH+1); no wrap past NCH.
//  - State encoding: ASSERT=0, WAIT_LOCK=1, RELEASE=2, RUN=3, DRAIN=4.
// CONFIGURATION
//  RST_SEQ_REVERSE_ASSERT_EN defined: sw_rst_req in RELEASE/RUN enters DRAIN; channels
//  re-asserted highest-released-first, one per HOLD_CYC (first at HOLD_CYC after entry);
//  all_released=0 on DRAIN entry; after ch0 asserted -> ASSERT. sw_rst_req during DRAIN
//  ignored; lock loss during DRAIN still forces immediate ASSERT.
//  Undefined: sw_rst_req forces all channels low on the next edge; DRAIN unreachable.
// STRUCTURE
//  Package rst_seq_pkg: state typedef enum logic[2:0] + encodings, LOCK_CNT_W=8, LOCK_CNT_MAX.
//  Sub-module sync_bit (#STAGES): plain flop chain for locked_in, reset clears to 0.
//  Top holds FSM, filt_cnt, hold_cnt, idx, lock_loss_cnt, output register.
// TESTING (defaults NCH=4, SYNC_STAGES=2, LOCK_FILT=16, HOLD_CYC=8)
//  1 locked_in=1 from cycle 0 after rst: RELEASE at 18; rst_n_out 0001@26, 0011@34, 0111@42,
//    1111+all_released@50.
//  2 locked_in glitches low 1 cycle at cycle 10 -> filter restarts; RELEASE delayed to lk-high+16.
//  3 In RUN, locked_in low -> rst_n_out=0000 within SYNC_STAGES+1 cycles, lock_loss_cnt=1;
//    relock -> full sequence repeats; 300 losses -> lock_loss_cnt=255.
//  4 sw_rst_req in RUN, macro off -> 0000 next edge, lock_loss_cnt unchanged; macro on ->
//    0111,0011,0001,0000 at +8,+16,+24,+32 then WAIT_LOCK.
//  5 sw_rst_req and lock loss same cycle (macro on) -> immediate 0000, cnt++, no DRAIN.
//  6 rst asserted mid-RELEASE (after 0011) -> all outputs/counters 0 next edge; NCH=1 build
//    releases ch0 with all_released at RELEASE+8.

Source files
------------

// File: rtl/rst_seq_pkg.sv
// Shared state encoding, lock-loss counter limits and width helper for the reset sequencer.
package rst_seq_pkg;

  typedef enum logic [2:0] {
    ST_ASSERT    = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_RELEASE   = 3'd2,
    ST_RUN       = 3'd3,
    ST_DRAIN     = 3'd4
  } state_t;

  localparam int LOCK_CNT_W = 8;
  localparam logic [LOCK_CNT_W-1:0] LOCK_CNT_MAX = '1;

  // Counter width able to hold 0..limit-1, never narrower than one bit.
  function automatic int cntWidth(input int limit);
    return (limit > 1) ? $clog2(limit) : 1;
  endfunction

endpackage

// File: rtl/sync_bit.sv
// Plain multi-flop synchroniser for a single asynchronous level; reset clears the chain to 0.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_chain;

  always_ff @(posedge clk) begin
    if (rst) r_chain <= '0;
    else     r_chain <= {r_chain[STAGES-2:0], i_d};
  end

  assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/rst_sequencer.sv
// Lock-filtered, staggered multi-domain reset sequencer with lock-loss counter.
// Optional RST_SEQ_REVERSE_ASSERT_EN: software requests drain channels highest-first.
module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int NCH         = 4,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_FILT   = 16,
  parameter int HOLD_CYC    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  locked_in,
  input  logic                  sw_rst_req,
  output logic [NCH-1:0]        rst_n_out,
  output logic                  all_released,
  output logic [2:0]            state_o,
  output logic [LOCK_CNT_W-1:0] lock_loss_cnt
);

  localparam int FILT_W = cntWidth(LOCK_FILT);
  localparam int HOLD_W = cntWidth(HOLD_CYC);
  localparam int IDX_W  = cntWidth(NCH + 1);
  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOCK_FILT - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NCH - 1);

`ifdef RST_SEQ_REVERSE_ASSERT_EN
  localparam state_t SW_TARGET = ST_DRAIN;
`else
  localparam state_t SW_TARGET = ST_ASSERT;
`endif

  state_t                  r_state;
  state_t                  w_stateNext;
  logic [FILT_W-1:0]       r_filtCnt;
  logic [FILT_W-1:0]       w_filtNext;
  logic [HOLD_W-1:0]       r_holdCnt;
  logic [HOLD_W-1:0]       w_holdNext;
  logic [IDX_W-1:0]        r_idx;
  logic [IDX_W-1:0]        w_idxNext;
  logic [LOCK_CNT_W-1:0]   r_lossCnt;
  logic [LOCK_CNT_W-1:0]   w_lossNext;
  logic [NCH-1:0]          r_rstN;
  logic [NCH-1:0]          w_rstNext;
  logic                    w_lk;
  logic                    w_holdWrap;
  logic                    w_lockLost;

  sync_bit #(.STAGES(SYNC_STAGES)) u_lockSync (
    .clk (clk),
    .rst (rst),
    .i_d (locked_in),
    .o_q (w_lk)
  );

  assign w_holdWrap = (r_holdCnt == HOLD_LAST);
  assign w_lockLost = !w_lk && (r_state == ST_RELEASE || r_state == ST_RUN ||
                                r_state == ST_DRAIN);

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_ASSERT;
    else     r_state <= w_stateNext;
  end

  // Lock loss outranks a software request raised in the same cycle.
  always_comb begin
    w_stateNext = r_state;
    unique case (r_state)
      ST_ASSERT:    w_stateNext = ST_WAIT_LOCK;
      ST_WAIT_LOCK: if (w_lk && r_filtCnt == FILT_LAST) w_stateNext = ST_RELEASE;
      ST_RELEASE: begin
        if (!w_lk)                             w_stateNext = ST_ASSERT;
        else if (sw_rst_req)                   w_stateNext = SW_TARGET;
        else if (w_holdWrap && r_idx == IDX_LAST) w_stateNext = ST_RUN;
      end
      ST_RUN: begin
        if (!w_lk)           w_stateNext = ST_ASSERT;
        else if (sw_rst_req) w_stateNext = SW_TARGET;
      end
      ST_DRAIN: begin
        if (!w_lk)                                   w_stateNext = ST_ASSERT;
        else if (w_holdWrap && r_idx <= IDX_W'(1))   w_stateNext = ST_ASSERT;
      end
      default:      w_stateNext = ST_ASSERT;
    endcase
  end

  // r_idx is the number of released channels; outputs form a thermometer of it.
  always_comb begin
    w_filtNext = '0;
    if (r_state == ST_WAIT_LOCK && w_lk && r_filtCnt != FILT_LAST)
      w_filtNext = r_filtCnt + 1'b1;

    w_holdNext = '0;
    if ((r_state == ST_RELEASE || r_state == ST_DRAIN) && w_stateNext == r_state && !w_holdWrap)
      w_holdNext = r_holdCnt + 1'b1;

    w_idxNext = r_idx;
    if (w_stateNext == ST_ASSERT)
      w_idxNext = '0;
    else if (w_holdWrap && r_state == ST_RELEASE && w_stateNext != ST_DRAIN)
      w_idxNext = r_idx + 1'b1;
    else if (w_holdWrap && r_state == ST_DRAIN)
      w_idxNext = r_idx - 1'b1;

    w_rstNext = '0;
    for (int k = 0; k < NCH; k++)
      w_rstNext[k] = (IDX_W'(k) < w_idxNext);

    w_lossNext = r_lossCnt;
    if (w_lockLost && r_lossCnt != LOCK_CNT_MAX)
      w_lossNext = r_lossCnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_filtCnt <= '0;
      r_holdCnt <= '0;
      r_idx     <= '0;
      r_lossCnt <= '0;
      r_rstN    <= '0;
    end else begin
      r_filtCnt <= w_filtNext;
      r_holdCnt <= w_holdNext;
      r_idx     <= w_idxNext;
      r_lossCnt <= w_lossNext;
      r_rstN    <= w_rstNext;
    end
  end

  assign rst_n_out     = r_rstN;
  assign all_released  = (r_state == ST_RUN);
  assign state_o       = r_state;
  assign lock_loss_cnt = r_lossCnt;

endmodule

// File: tb/tb_rst_sequencer.sv
// Bench for rst_sequencer: hand vectors, corner sequences and random traffic against a timestamp model.
module tb_rst_sequencer;

  localparam int NCH  = 4;
  localparam int SYNC = 2;
  localparam int FILT = 16;
  localparam int HOLD = 8;

  localparam int M_ASSERT = 0;
  localparam int M_WAIT   = 1;
  localparam int M_ACTIVE = 2;
  localparam int M_DRAIN  = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           locked_in = 1'b0;
  logic           sw_rst_req = 1'b0;
  logic [NCH-1:0] rst_n_out;
  logic           all_released;
  logic [2:0]     state_o;
  logic [7:0]     lock_loss_cnt;
  logic [0:0]     u1RstN;
  logic           u1All;
  logic [2:0]     u1State;
  logic [7:0]     u1Cnt;

  rst_sequencer #(.NCH(NCH), .SYNC_STAGES(SYNC), .LOCK_FILT(FILT), .HOLD_CYC(HOLD)) dut (
    .clk           (clk),
    .rst           (rst),
    .locked_in     (locked_in),
    .sw_rst_req    (sw_rst_req),
    .rst_n_out     (rst_n_out),
    .all_released  (all_released),
    .state_o       (state_o),
    .lock_loss_cnt (lock_loss_cnt)
  );

  rst_sequencer #(.NCH(1), .SYNC_STAGES(SYNC), .LOCK_FILT(FILT), .HOLD_CYC(HOLD)) dut1 (
    .clk           (clk),
    .rst           (rst),
    .locked_in     (locked_in),
    .sw_rst_req    (sw_rst_req),
    .rst_n_out     (u1RstN),
    .all_released  (u1All),
    .state_o       (u1State),
    .lock_loss_cnt (u1Cnt)
  );

  always #5 clk = ~clk;

  int nTests = 0;
  int nFail  = 0;

  // Reference model: remembers when releasing/draining began and derives channel counts by division.
  int             edgeNo = 0;
  int             mMode = M_ASSERT;
  int             mRelEdge = 0;
  int             mDrainEdge = 0;
  int             mDrainStart = 0;
  int             mWRun = 0;
  int             mLoss = 0;
  logic [SYNC-1:0] mHist = '0;

  function automatic int mCount();
    int k;
    if (mMode == M_ACTIVE) begin
      k = (edgeNo - mRelEdge) / HOLD;
      return (k > NCH) ? NCH : k;
    end
    if (mMode == M_DRAIN) begin
      k = mDrainStart - (edgeNo - mDrainEdge) / HOLD;
      return (k < 0) ? 0 : k;
    end
    return 0;
  endfunction

  function automatic logic [2:0] mState();
    if (mMode == M_ACTIVE) return (mCount() == NCH) ? 3'd3 : 3'd2;
    return 3'(mMode);
  endfunction

  function automatic logic [NCH-1:0] mRstN();
    logic [NCH-1:0] v;
    int c;
    c = mCount();
    v = '0;
    for (int k = 0; k < NCH; k++) v[k] = (k < c);
    return v;
  endfunction

  task automatic modelStep();
    logic lkPre;
    int   pre;
    int   need;
    lkPre = mHist[SYNC-1];
    edgeNo++;
    if (rst) begin
      mMode = M_ASSERT;
      mLoss = 0;
      mHist = '0;
      return;
    end
    case (mMode)
      M_ASSERT: begin
        mMode = M_WAIT;
        mWRun = 0;
      end
      M_WAIT: begin
        mWRun = lkPre ? mWRun + 1 : 0;
        if (mWRun == FILT) begin
          mMode    = M_ACTIVE;
          mRelEdge = edgeNo;
        end
      end
      M_ACTIVE: begin
        pre = (edgeNo - 1 - mRelEdge) / HOLD;
        if (pre > NCH) pre = NCH;
        if (!lkPre) begin
          mMode = M_ASSERT;
          if (mLoss < 255) mLoss++;
        end else if (sw_rst_req) begin
`ifdef RST_SEQ_REVERSE_ASSERT_EN
          mMode       = M_DRAIN;
          mDrainEdge  = edgeNo;
          mDrainStart = pre;
`else
          mMode = M_ASSERT;
`endif
        end
      end
      M_DRAIN: begin
        need = (mDrainStart > 1) ? mDrainStart : 1;
        if (!lkPre) begin
          mMode = M_ASSERT;
          if (mLoss < 255) mLoss++;
        end else if ((edgeNo - mDrainEdge) / HOLD >= need) begin
          mMode = M_ASSERT;
        end
      end
      default: mMode = M_ASSERT;
    endcase
    mHist = {mHist[SYNC-2:0], locked_in};
  endtask

  task automatic checkOutput(input string name, input logic [NCH-1:0] expRstN, input logic expAll,
                             input logic [2:0] expState, input logic [7:0] expCnt);
    nTests++;
    if (rst_n_out !== expRstN || all_released !== expAll || state_o !== expState ||
        lock_loss_cnt !== expCnt) begin
      nFail++;
      $display("[TB] FAIL %s @edge %0d: got rst_n=%b all=%b st=%0d cnt=%0d, want rst_n=%b all=%b st=%0d cnt=%0d",
               name, edgeNo, rst_n_out, all_released, state_o, lock_loss_cnt,
               expRstN, expAll, expState, expCnt);
    end
  endtask

  // One clock of stimulus, followed by a comparison against the model.
  task automatic applyStimulus(input logic lockIn, input logic sw, input logic r);
    locked_in  = lockIn;
    sw_rst_req = sw;
    rst        = r;
    modelStep();
    @(posedge clk);
    #1;
    checkOutput("model", mRstN(), (mState() == 3'd3), mState(), 8'(mLoss));
  endtask

  typedef struct {
    int             cycles;
    logic           lockIn;
    logic           sw;
    logic           r;
    logic [NCH-1:0] expRstN;
    logic           expAll;
    logic [2:0]     expState;
    logic [7:0]     expCnt;
  } vec_t;

  vec_t vecs[$];

  function automatic void addVec(input int cyc, input logic lk, input logic sw, input logic r,
                                 input logic [NCH-1:0] rn, input logic al, input logic [2:0] st,
                                 input logic [7:0] cn);
    vec_t v;
    v.cycles = cyc; v.lockIn = lk; v.sw = sw; v.r = r;
    v.expRstN = rn; v.expAll = al; v.expState = st; v.expCnt = cn;
    vecs.push_back(v);
  endfunction

  initial begin
    int  guard;
    logic lk, sw, r;

    // Clean lock from reset, a lock loss in RUN, relock, then a software request.
    addVec(2,  1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 3'd0, 8'd0);
    addVec(1,  1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 3'd1, 8'd0);
    addVec(16, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 3'd1, 8'd0);
    addVec(1,  1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 3'd2, 8'd0);
    addVec(8,  1'b1, 1'b0, 1'b0, 4'b0001, 1'b0, 3'd2, 8'd0);
    addVec(8,  1'b1, 1'b0, 1'b0, 4'b0011, 1'b0, 3'd2, 8'd0);
    addVec(8,  1'b1, 1'b0, 1'b0, 4'b0111, 1'b0, 3'd2, 8'd0);
    addVec(7,  1'b1, 1'b0, 1'b0, 4'b0111, 1'b0, 3'd2, 8'd0);
    addVec(1,  1'b1, 1'b0, 1'b0, 4'b1111, 1'b1, 3'd3, 8'd0);
    addVec(5,  1'b1, 1'b0, 1'b0, 4'b1111, 1'b1, 3'd3, 8'd0);
    addVec(2,  1'b0, 1'b0, 1'b0, 4'b1111, 1'b1, 3'd3, 8'd0);
    addVec(1,  1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 3'd0, 8'd1);
    addVec(1,  1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 3'd1, 8'd1);
    addVec(1,  1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 3'd1, 8'd1);
    addVec(15, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 3'd1, 8'd1);
    addVec(1,  1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 3'd2, 8'd1);
    addVec(32, 1'b1, 1'b0, 1'b0, 4'b1111, 1'b1, 3'd3, 8'd1);
`ifdef RST_SEQ_REVERSE_ASSERT_EN
    addVec(1,  1'b1, 1'b1, 1'b0, 4'b1111, 1'b0, 3'd4, 8'd1);
    addVec(1,  1'b1, 1'b0, 1'b0, 4'b1111, 1'b0, 3'd4, 8'd1);
    addVec(7,  1'b1, 1'b0, 1'b0, 4'b0111, 1'b0, 3'd4, 8'd1);
    addVec(24, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 3'd0, 8'd1);
`else
    addVec(1,  1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 3'd0, 8'd1);
    addVec(1,  1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 3'd1, 8'd1);
    addVec(7,  1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 3'd1, 8'd1);
    addVec(24, 1'b1, 1'b0, 1'b0, 4'b0001, 1'b0, 3'd2, 8'd1);
`endif

    foreach (vecs[i]) begin
      for (int c = 0; c < vecs[i].cycles; c++)
        applyStimulus(vecs[i].lockIn, vecs[i].sw, vecs[i].r);
      checkOutput($sformatf("vec%0d", i), vecs[i].expRstN, vecs[i].expAll,
                  vecs[i].expState, vecs[i].expCnt);
    end

    // Reset asserted mid-release once two channels are out.
    guard = 0;
    while (rst_n_out !== 4'b0011 && guard < 100) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      guard++;
    end
    nTests++;
    if (guard >= 100) begin
      nFail++;
      $display("[TB] FAIL wait0011: got rst_n=%b after %0d cycles, want 0011", rst_n_out, guard);
    end
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("midReset", 4'b0000, 1'b0, 3'd0, 8'd0);

    // Single-cycle lock glitch at edge 10 restarts the filter; NCH=1 instance checked alongside.
    applyStimulus(1'b1, 1'b0, 1'b1);
    for (int c = 0; c < 9; c++) applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 17; c++) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("glitchWait", 4'b0000, 1'b0, 3'd1, 8'd0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("glitchRelease", 4'b0000, 1'b0, 3'd2, 8'd0);

    for (int c = 0; c < 7; c++) applyStimulus(1'b1, 1'b0, 1'b0);
    nTests++;
    if (u1RstN !== 1'b0 || u1All !== 1'b0 || u1State !== 3'd2 || u1Cnt !== 8'd0) begin
      nFail++;
      $display("[TB] FAIL nch1Before: got rst_n=%b all=%b st=%0d cnt=%0d, want 0 0 2 0",
               u1RstN, u1All, u1State, u1Cnt);
    end
    applyStimulus(1'b1, 1'b0, 1'b0);
    nTests++;
    if (u1RstN !== 1'b1 || u1All !== 1'b1 || u1State !== 3'd3) begin
      nFail++;
      $display("[TB] FAIL nch1Release: got rst_n=%b all=%b st=%0d, want 1 1 3",
               u1RstN, u1All, u1State);
    end

    // Lock loss and software request seen in the same cycle: immediate assert, counted.
    for (int c = 0; c < 24; c++) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("runReached", 4'b1111, 1'b1, 3'd3, 8'd0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("lossPlusSw", 4'b0000, 1'b0, 3'd0, 8'd1);

    // 300 lock losses during RELEASE saturate the counter.
    applyStimulus(1'b1, 1'b0, 1'b1);
    for (int n = 0; n < 300; n++) begin
      guard = 0;
      while (state_o !== 3'd2 && guard < 40) begin
        applyStimulus(1'b1, 1'b0, 1'b0);
        guard++;
      end
      if (guard >= 40) begin
        nTests++;
        nFail++;
        $display("[TB] FAIL waitRelease: got st=%0d after %0d cycles, want 2", state_o, guard);
        break;
      end
      for (int c = 0; c < 3; c++) applyStimulus(1'b0, 1'b0, 1'b0);
    end
    checkOutput("saturate", 4'b0000, 1'b0, 3'd0, 8'd255);

    // Random lock drops, software requests and occasional resets.
    applyStimulus(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3000; i++) begin
      lk = ($urandom_range(0, 99) >= 4);
      sw = ($urandom_range(0, 99) < 2);
      r  = ($urandom_range(0, 999) < 5);
      applyStimulus(lk, sw, r);
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
